// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle for seg7_scan_driver: load/value/config inputs and the
// registered segment, anode and frame outputs.
interface seg7_scan_driver_if #(
    parameter int DIGITS = 4
) ();
    logic                  load;
    logic [4*DIGITS-1:0]   value_in;
    logic [DIGITS-1:0]     dp_in;
    logic                  lzb_en;
    logic [DIGITS-1:0]     blink_mask;
    logic [6:0]            seg_out;
    logic                  dp_out;
    logic [DIGITS-1:0]     an_out;
    logic                  frame_tick;

    modport master (
        output load, value_in, dp_in, lzb_en, blink_mask,
        input  seg_out, dp_out, an_out, frame_tick
    );

    modport slave (
        input  load, value_in, dp_in, lzb_en, blink_mask,
        output seg_out, dp_out, an_out, frame_tick
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with leading-zero blanking,
// per-digit blink and decimal points. SEG7_HEX_EN enables A-F glyphs.
module seg7_scan_driver #(
    parameter int DIGITS       = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    seg7_scan_driver_if.slave  bus
);
    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(DIGITS);
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [4*DIGITS-1:0] disp_reg_r;
    logic [DIGITS-1:0]   dp_reg_r;
    logic [DIV_W-1:0]    div_cnt_r;
    logic [IDX_W-1:0]    idx_r;
    logic [FRM_W-1:0]    frm_cnt_r;
    logic                blink_phase_r;
    logic [6:0]          seg_r;
    logic                dp_r;
    logic [DIGITS-1:0]   an_r;
    logic                frame_tick_r;

    logic                div_wrap_s;
    logic                idx_wrap_s;
    logic                frm_wrap_s;
    logic [3:0]          cur_nib_s;
    logic                cur_dp_s;
    logic                cur_blink_s;
    logic                cur_lz_s;
    logic                blank_s;
    logic [6:0]          seg_next_s;
    logic                dp_next_s;
    logic [DIGITS-1:0]   an_next_s;

    // Active-low glyph table; unsupported nibbles go dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'h0: seg_decode = 7'h40;
            4'h1: seg_decode = 7'h79;
            4'h2: seg_decode = 7'h24;
            4'h3: seg_decode = 7'h30;
            4'h4: seg_decode = 7'h19;
            4'h5: seg_decode = 7'h12;
            4'h6: seg_decode = 7'h02;
            4'h7: seg_decode = 7'h78;
            4'h8: seg_decode = 7'h00;
            4'h9: seg_decode = 7'h10;
`ifdef SEG7_HEX_EN
            4'hA: seg_decode = 7'h08;
            4'hB: seg_decode = 7'h03;
            4'hC: seg_decode = 7'h46;
            4'hD: seg_decode = 7'h21;
            4'hE: seg_decode = 7'h06;
            4'hF: seg_decode = 7'h0E;
`else
            4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF: seg_decode = 7'h7F;
`endif
            default: seg_decode = 7'h7F;
        endcase
    endfunction

    assign div_wrap_s = (div_cnt_r == DIV_W'(REFRESH_DIV - 1));
    assign idx_wrap_s = div_wrap_s && (idx_r == IDX_W'(DIGITS - 1));
    assign frm_wrap_s = idx_wrap_s && (frm_cnt_r == FRM_W'(BLINK_FRAMES - 1));

    // Select the scanned digit's fields; zero_run tracks "this nibble and all above are zero".
    always_comb begin : digit_sel
        logic zero_run;
        logic hit;
        zero_run    = 1'b1;
        hit         = 1'b0;
        cur_nib_s   = 4'h0;
        cur_dp_s    = 1'b0;
        cur_blink_s = 1'b0;
        cur_lz_s    = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run    = zero_run & (disp_reg_r[4*i +: 4] == 4'h0);
            hit         = (idx_r == IDX_W'(i));
            cur_nib_s   = cur_nib_s | (disp_reg_r[4*i +: 4] & {4{hit}});
            cur_dp_s    = cur_dp_s | (dp_reg_r[i] & hit);
            cur_blink_s = cur_blink_s | (bus.blink_mask[i] & hit);
            cur_lz_s    = cur_lz_s | (zero_run & hit);
        end
    end

    // Blanking decision and next output values for the scanned digit.
    always_comb begin
        blank_s = 1'b0;
        if ((bus.lzb_en && (idx_r != {IDX_W{1'b0}}) && cur_lz_s) ||
            (cur_blink_s && blink_phase_r)) begin
            blank_s = 1'b1;
        end else begin
            blank_s = 1'b0;
        end
        seg_next_s = blank_s ? 7'h7F : seg_decode(cur_nib_s);
        dp_next_s  = blank_s ? 1'b1 : ~cur_dp_s;
        an_next_s  = ~({{(DIGITS-1){1'b0}}, 1'b1} << idx_r);
    end

    // Refresh divider, digit index, frame counter and blink phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_r     <= {DIV_W{1'b0}};
            idx_r         <= {IDX_W{1'b0}};
            frm_cnt_r     <= {FRM_W{1'b0}};
            blink_phase_r <= 1'b0;
        end else begin
            div_cnt_r <= div_wrap_s ? {DIV_W{1'b0}} : div_cnt_r + DIV_W'(1);
            if (div_wrap_s) begin
                idx_r <= idx_wrap_s ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
            end
            if (idx_wrap_s) begin
                frm_cnt_r <= frm_wrap_s ? {FRM_W{1'b0}} : frm_cnt_r + FRM_W'(1);
            end
            if (frm_wrap_s) begin
                blink_phase_r <= ~blink_phase_r;
            end
        end
    end

    // Display and decimal-point registers; a load may land mid-frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp_reg_r <= {(4*DIGITS){1'b0}};
            dp_reg_r   <= {DIGITS{1'b0}};
        end else if (bus.load) begin
            disp_reg_r <= bus.value_in;
            dp_reg_r   <= bus.dp_in;
        end
    end

    // Registered pin drivers, one cycle behind the scan state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_r        <= 7'h7F;
            dp_r         <= 1'b1;
            an_r         <= {DIGITS{1'b1}};
            frame_tick_r <= 1'b0;
        end else begin
            seg_r        <= seg_next_s;
            dp_r         <= dp_next_s;
            an_r         <= an_next_s;
            frame_tick_r <= idx_wrap_s;
        end
    end

    assign bus.seg_out    = seg_r;
    assign bus.dp_out     = dp_r;
    assign bus.an_out     = an_r;
    assign bus.frame_tick = frame_tick_r;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2).
module tb_seg7_scan_driver;
    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;

    seg7_scan_driver_if #(.DIGITS(4)) bus ();

    seg7_scan_driver #(
        .DIGITS(4), .REFRESH_DIV(4), .BLINK_FRAMES(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_seg"}, 32'(bus.seg_out), 32'h7F);
        check_eq({tag, "_dp"}, 32'(bus.dp_out), 32'h1);
        check_eq({tag, "_an"}, 32'(bus.an_out), 32'hF);
        check_eq({tag, "_ft"}, 32'(bus.frame_tick), 32'h0);
    endtask

    task automatic load_val(input logic [15:0] v, input logic [3:0] dp);
        bus.value_in = v;
        bus.dp_in    = dp;
        bus.load     = 1'b1;
        tick();
        bus.load     = 1'b0;
    endtask

    // Wait (bounded) for digit d to be lit, then compare its segments and dp.
    task automatic show_digit(input int d, input logic [6:0] exp_seg, input logic exp_dp, input string tag);
        logic [3:0] tgt;
        int n;
        tgt = ~(4'b0001 << d);
        tick();
        n = 0;
        while (bus.an_out !== tgt && n < 20) begin
            tick();
            n++;
        end
        check_eq({tag, "_an"}, 32'(bus.an_out), 32'(tgt));
        check_eq({tag, "_seg"}, 32'(bus.seg_out), 32'(exp_seg));
        check_eq({tag, "_dp"}, 32'(bus.dp_out), 32'(exp_dp));
    endtask

    // Cycle-exact scan check from reset release with an all-zero display.
    task automatic scan_run(input int ncyc, input bit blink);
        int d;
        int f;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        for (int k = 1; k <= ncyc; k++) begin
            tick();
            d = ((k - 1) / 4) % 4;
            f = (k - 1) / 16;
            exp_an = ~(4'b0001 << d);
            exp_seg = (blink && d == 0 && ((f / 2) % 2 == 1)) ? 7'h7F : 7'h40;
            check_eq($sformatf("scan_an_k%0d", k), 32'(bus.an_out), 32'(exp_an));
            check_eq($sformatf("scan_seg_k%0d", k), 32'(bus.seg_out), 32'(exp_seg));
            check_eq($sformatf("scan_dp_k%0d", k), 32'(bus.dp_out), 32'h1);
            check_eq($sformatf("scan_ft_k%0d", k), 32'(bus.frame_tick), (k % 16 == 0) ? 32'h1 : 32'h0);
        end
    endtask

    initial begin
        int n;
        n_checks = 0;
        n_errors = 0;
        reset_n = 1'b0;
        bus.load = 1'b0;
        bus.value_in = 16'h0000;
        bus.dp_in = 4'b0000;
        bus.lzb_en = 1'b0;
        bus.blink_mask = 4'b0000;
        tick(); tick(); tick();
        check_reset_outputs("rst");

        reset_n = 1'b1;
        scan_run(32, 1'b0);

        load_val(16'h1234, 4'b0100);
        show_digit(0, 7'h19, 1'b1, "v1234_d0");
        show_digit(1, 7'h30, 1'b1, "v1234_d1");
        show_digit(2, 7'h24, 1'b0, "v1234_d2");
        show_digit(3, 7'h79, 1'b1, "v1234_d3");

        load_val(16'h9876, 4'b0000);
        show_digit(0, 7'h02, 1'b1, "v9876_d0");
        show_digit(1, 7'h78, 1'b1, "v9876_d1");
        show_digit(2, 7'h00, 1'b1, "v9876_d2");
        show_digit(3, 7'h10, 1'b1, "v9876_d3");

        bus.lzb_en = 1'b1;
        load_val(16'h0050, 4'b1000);
        show_digit(3, 7'h7F, 1'b1, "lz0050_d3");
        show_digit(2, 7'h7F, 1'b1, "lz0050_d2");
        show_digit(1, 7'h12, 1'b1, "lz0050_d1");
        show_digit(0, 7'h40, 1'b1, "lz0050_d0");

        load_val(16'h0000, 4'b0000);
        show_digit(0, 7'h40, 1'b1, "lz0000_d0");
        show_digit(1, 7'h7F, 1'b1, "lz0000_d1");
        show_digit(2, 7'h7F, 1'b1, "lz0000_d2");
        show_digit(3, 7'h7F, 1'b1, "lz0000_d3");

        load_val(16'h1005, 4'b0000);
        show_digit(3, 7'h79, 1'b1, "lz1005_d3");
        show_digit(2, 7'h40, 1'b1, "lz1005_d2");
        show_digit(1, 7'h40, 1'b1, "lz1005_d1");
        show_digit(0, 7'h12, 1'b1, "lz1005_d0");

        bus.lzb_en = 1'b0;
        load_val(16'h00AF, 4'b0000);
`ifdef SEG7_HEX_EN
        show_digit(0, 7'h0E, 1'b1, "hex_d0");
        show_digit(1, 7'h08, 1'b1, "hex_d1");
`else
        show_digit(0, 7'h7F, 1'b1, "hex_d0");
        show_digit(1, 7'h7F, 1'b1, "hex_d1");
`endif
        show_digit(2, 7'h40, 1'b1, "hex_d2");
        show_digit(3, 7'h40, 1'b1, "hex_d3");

        // Blink on digit 0 from a known reset point.
        reset_n = 1'b0;
        bus.blink_mask = 4'b0001;
        tick();
        check_reset_outputs("rst2");
        reset_n = 1'b1;
        scan_run(96, 1'b1);

        // Asynchronous reset while digit 2 is lit.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        n = 0;
        while (bus.an_out !== 4'b1011 && n < 40) begin
            tick();
            n++;
        end
        check_eq("async_reach_d2", 32'(bus.an_out), 32'hB);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async");
        #2;
        reset_n = 1'b1;
        tick();
        check_eq("post_async_an", 32'(bus.an_out), 32'hE);
        check_eq("post_async_seg", 32'(bus.seg_out), 32'h40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
